// File: rtl/tx_tlp_builder.sv
// tx_tlp_builder: serialises one PCIe request TLP (header then payload) as a
// DW stream from the latched request fields and a fall-through payload FIFO.
// Optional end-to-end digest DW is enabled by defining TX_TLP_DIGEST_EN.
module tx_tlp_builder #(
    parameter logic [15:0] REQUESTER_ID   = 16'h0100,
    parameter int          MAX_PAYLOAD_DW = 32,
    parameter int          TAG_WIDTH      = 5
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [2:0]  i_tlp_type,
    input  logic        i_addr_64,
    input  logic        i_read_write,
    input  logic        i_config_type,
    input  logic [11:0] i_byte_count,
    input  logic [31:0] i_lower_addr,
    input  logic [31:0] i_upper_addr,
    input  logic [15:0] i_dest_bdf_id,
    input  logic [9:0]  i_config_dw_number,
    input  logic        i_valid,
    input  logic [31:0] i_payload_data,
    input  logic        i_payload_empty,
    output logic        o_payload_rd_en,
    output logic        o_finished,
    output logic        o_error,
    output logic [31:0] o_tlp_data,
    output logic        o_tlp_sop,
    output logic        o_tlp_eop,
    output logic        o_tlp_valid,
    input  logic        i_tlp_ready
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_HDR      = 3'd2,
        ST_DATA     = 3'd3,
        ST_DONE     = 3'd4,
        ST_WAIT_CLR = 3'd5,
        ST_DIGEST   = 3'd6
    } state_t;

`ifdef TX_TLP_DIGEST_EN
    localparam state_t ST_AFTER_LAST = ST_DIGEST;
    localparam logic   TD_BIT        = 1'b1;
`else
    localparam state_t ST_AFTER_LAST = ST_DONE;
    localparam logic   TD_BIT        = 1'b0;
`endif

    // Byte-enable nibble for the partial DW implied by byte_count[1:0].
    function automatic logic [3:0] be_from_rem(input logic [1:0] rem);
        case (rem)
            2'd1:    be_from_rem = 4'b0001;
            2'd2:    be_from_rem = 4'b0011;
            2'd3:    be_from_rem = 4'b0111;
            default: be_from_rem = 4'b1111;
        endcase
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic [2:0]             type_r;
    logic                   addr64_r;
    logic                   write_r;
    logic                   cfg1_r;
    logic [11:0]            bc_r;
    logic [29:0]            lower_r;
    logic [31:0]            upper_r;
    logic [15:0]            bdf_r;
    logic [9:0]             dwn_r;
    logic                   err_r;
    logic [1:0]             hdr_idx_r;
    logic [10:0]            cnt_r;
`ifdef TX_TLP_DIGEST_EN
    logic [31:0]            digest_r;
`endif

    logic                   is_mem_s;
    logic                   is_io_s;
    logic                   is_cfg_s;
    logic [10:0]            len_raw_s;
    logic [10:0]            len_s;
    logic                   hdr4_s;
    logic [1:0]             last_idx_s;
    logic                   hdr_last_s;
    logic [3:0]             rem_be_s;
    logic [3:0]             first_be_s;
    logic [3:0]             last_be_s;
    logic [4:0]             type5_s;
    logic [7:0]             tag8_s;
    logic [31:0]            dw0_s;
    logic [31:0]            dw1_s;
    logic [31:0]            dw2_s;
    logic [31:0]            dw3_s;
    logic [31:0]            hdr_dw_s;
    logic                   check_err_s;
    logic                   data_xfer_s;
    logic                   unused_s;

    // Address bits below DW alignment never reach the header.
    assign unused_s = ^i_lower_addr[1:0];

    assign is_mem_s    = (type_r == 3'd0);
    assign is_io_s     = (type_r == 3'd1);
    assign is_cfg_s    = (type_r == 3'd2);
    // ceil(byte_count/4); 4095 bytes rounds to 1024 which fits in 11 bits.
    assign len_raw_s   = {1'b0, bc_r[11:2]} + {10'd0, (bc_r[1:0] != 2'b00)};
    assign len_s       = !is_mem_s ? 11'd1 : ((len_raw_s == 11'd0) ? 11'd1 : len_raw_s);
    assign hdr4_s      = is_mem_s && addr64_r;
    assign last_idx_s  = hdr4_s ? 2'd3 : 2'd2;
    assign hdr_last_s  = (hdr_idx_r == last_idx_s);
    assign rem_be_s    = be_from_rem(bc_r[1:0]);
    assign first_be_s  = (len_s == 11'd1) ? rem_be_s : 4'b1111;
    assign last_be_s   = (len_s == 11'd1) ? 4'b0000 : rem_be_s;
    assign tag8_s      = {{(8-TAG_WIDTH){1'b0}}, tag_r};
    assign check_err_s = !(is_mem_s || is_io_s || is_cfg_s) ||
                         (write_r && (len_s > 11'(MAX_PAYLOAD_DW)));
    assign data_xfer_s = !i_payload_empty && i_tlp_ready;

    // Header DW assembly from the latched request fields.
    always_comb begin
        type5_s = 5'b00000;
        case (type_r)
            3'd1:    type5_s = 5'b00010;
            3'd2:    type5_s = cfg1_r ? 5'b00101 : 5'b00100;
            default: type5_s = 5'b00000;
        endcase
        // Length is 10 bits; a 1024-DW length wraps to 0 as the encoding requires.
        dw0_s = {1'b0, write_r, hdr4_s, type5_s, 8'h00, TD_BIT, 5'b00000, len_s[9:0]};
        dw1_s = {REQUESTER_ID, tag8_s, last_be_s, first_be_s};
        dw3_s = {lower_r, 2'b00};
        if (is_cfg_s) begin
            dw2_s = {bdf_r, 4'h0, dwn_r[9:6], dwn_r[5:0], 2'b00};
        end else if (hdr4_s) begin
            dw2_s = upper_r;
        end else begin
            dw2_s = {lower_r, 2'b00};
        end
        case (hdr_idx_r)
            2'd0:    hdr_dw_s = dw0_s;
            2'd1:    hdr_dw_s = dw1_s;
            2'd2:    hdr_dw_s = dw2_s;
            default: hdr_dw_s = dw3_s;
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_valid) state_nxt_s = ST_CHECK;
                else         state_nxt_s = ST_IDLE;
            end
            ST_CHECK: begin
                if (check_err_s) state_nxt_s = ST_DONE;
                else             state_nxt_s = ST_HDR;
            end
            ST_HDR: begin
                if (i_tlp_ready && hdr_last_s) begin
                    if (write_r) state_nxt_s = ST_DATA;
                    else         state_nxt_s = ST_AFTER_LAST;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (data_xfer_s && (cnt_r == 11'd1)) state_nxt_s = ST_AFTER_LAST;
                else                                 state_nxt_s = ST_DATA;
            end
            ST_DIGEST: begin
                if (i_tlp_ready) state_nxt_s = ST_DONE;
                else             state_nxt_s = ST_DIGEST;
            end
            ST_DONE: state_nxt_s = ST_WAIT_CLR;
            ST_WAIT_CLR: begin
                // Hold off until the upstream level clears so a stale request is not re-issued.
                if (!i_valid) state_nxt_s = ST_IDLE;
                else          state_nxt_s = ST_WAIT_CLR;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode: stream handshake, FIFO pop and completion pulses.
    always_comb begin
        o_tlp_valid     = 1'b0;
        o_tlp_data      = 32'h0000_0000;
        o_tlp_sop       = 1'b0;
        o_tlp_eop       = 1'b0;
        o_payload_rd_en = 1'b0;
        o_finished      = 1'b0;
        o_error         = 1'b0;
        case (state_r)
            ST_HDR: begin
                o_tlp_valid = 1'b1;
                o_tlp_data  = hdr_dw_s;
                o_tlp_sop   = (hdr_idx_r == 2'd0);
`ifdef TX_TLP_DIGEST_EN
                o_tlp_eop   = 1'b0;
`else
                o_tlp_eop   = !write_r && hdr_last_s;
`endif
            end
            ST_DATA: begin
                o_tlp_valid     = !i_payload_empty;
                o_tlp_data      = i_payload_data;
                o_payload_rd_en = data_xfer_s;
`ifdef TX_TLP_DIGEST_EN
                o_tlp_eop       = 1'b0;
`else
                o_tlp_eop       = (cnt_r == 11'd1);
`endif
            end
`ifdef TX_TLP_DIGEST_EN
            ST_DIGEST: begin
                o_tlp_valid = 1'b1;
                o_tlp_data  = digest_r;
                o_tlp_eop   = 1'b1;
            end
`endif
            ST_DONE: begin
                o_finished = 1'b1;
                o_error    = err_r;
            end
            default: begin
                o_tlp_valid = 1'b0;
            end
        endcase
    end

    // Request capture, header index, payload counter, tag and digest.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tag_r     <= '0;
            type_r    <= 3'd0;
            addr64_r  <= 1'b0;
            write_r   <= 1'b0;
            cfg1_r    <= 1'b0;
            bc_r      <= 12'd0;
            lower_r   <= 30'd0;
            upper_r   <= 32'd0;
            bdf_r     <= 16'd0;
            dwn_r     <= 10'd0;
            err_r     <= 1'b0;
            hdr_idx_r <= 2'd0;
            cnt_r     <= 11'd0;
`ifdef TX_TLP_DIGEST_EN
            digest_r  <= 32'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        type_r   <= i_tlp_type;
                        addr64_r <= i_addr_64;
                        write_r  <= i_read_write;
                        cfg1_r   <= i_config_type;
                        bc_r     <= i_byte_count;
                        lower_r  <= i_lower_addr[31:2];
                        upper_r  <= i_upper_addr;
                        bdf_r    <= i_dest_bdf_id;
                        dwn_r    <= i_config_dw_number;
                    end
                end
                ST_CHECK: begin
                    err_r     <= check_err_s;
                    hdr_idx_r <= 2'd0;
`ifdef TX_TLP_DIGEST_EN
                    digest_r  <= 32'd0;
`endif
                end
                ST_HDR: begin
                    if (i_tlp_ready) begin
                        hdr_idx_r <= hdr_idx_r + 2'd1;
                        cnt_r     <= len_s;
`ifdef TX_TLP_DIGEST_EN
                        digest_r  <= digest_r ^ hdr_dw_s;
`endif
                    end
                end
                ST_DATA: begin
                    if (data_xfer_s) begin
                        cnt_r    <= cnt_r - 11'd1;
`ifdef TX_TLP_DIGEST_EN
                        digest_r <= digest_r ^ i_payload_data;
`endif
                    end
                end
                ST_DONE: begin
                    // Only TLPs that actually went out consume a tag.
                    if (!err_r) tag_r <= tag_r + {{(TAG_WIDTH-1){1'b0}}, 1'b1};
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_tlp_builder.sv
// Directed testbench for tx_tlp_builder (default build, digest disabled).
module tb_tx_tlp_builder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [2:0]  i_tlp_type;
    logic        i_addr_64;
    logic        i_read_write;
    logic        i_config_type;
    logic [11:0] i_byte_count;
    logic [31:0] i_lower_addr;
    logic [31:0] i_upper_addr;
    logic [15:0] i_dest_bdf_id;
    logic [9:0]  i_config_dw_number;
    logic        i_valid;
    logic [31:0] i_payload_data;
    logic        i_payload_empty;
    logic        o_payload_rd_en;
    logic        o_finished;
    logic        o_error;
    logic [31:0] o_tlp_data;
    logic        o_tlp_sop;
    logic        o_tlp_eop;
    logic        o_tlp_valid;
    logic        i_tlp_ready;

    always #5 aclk = ~aclk;

    tx_tlp_builder dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_tlp_type(i_tlp_type), .i_addr_64(i_addr_64), .i_read_write(i_read_write),
        .i_config_type(i_config_type), .i_byte_count(i_byte_count),
        .i_lower_addr(i_lower_addr), .i_upper_addr(i_upper_addr),
        .i_dest_bdf_id(i_dest_bdf_id), .i_config_dw_number(i_config_dw_number),
        .i_valid(i_valid), .i_payload_data(i_payload_data), .i_payload_empty(i_payload_empty),
        .o_payload_rd_en(o_payload_rd_en), .o_finished(o_finished), .o_error(o_error),
        .o_tlp_data(o_tlp_data), .o_tlp_sop(o_tlp_sop), .o_tlp_eop(o_tlp_eop),
        .o_tlp_valid(o_tlp_valid), .i_tlp_ready(i_tlp_ready)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] cap_dw [0:63];
    logic [63:0] sop_m, eop_m;
    int          n_cap, n_pops, first_cyc;
    bit          fin_seen, err_seen;
    logic [31:0] exp_dw [0:63];
    int          exp_n;
    logic [63:0] exp_eop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo(input bit force_empty);
        i_payload_empty = force_empty || (fifo_q.size() == 0);
        i_payload_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0000_0000;
    endtask

    task automatic req(input logic [2:0] ty, input bit a64, input bit wr, input bit c1,
                       input logic [11:0] bc, input logic [31:0] lo, input logic [31:0] up,
                       input logic [15:0] bdf, input logic [9:0] dwn);
        @(negedge aclk);
        i_tlp_type = ty; i_addr_64 = a64; i_read_write = wr; i_config_type = c1;
        i_byte_count = bc; i_lower_addr = lo; i_upper_addr = up;
        i_dest_bdf_id = bdf; i_config_dw_number = dwn;
        i_valid = 1'b1;
    endtask

    // Capture one TLP until o_finished, with optional ready toggling and a 3-cycle FIFO bubble.
    task automatic collect(input int budget, input bit toggle, input int bub0, input bit hold);
        bit          pend_pop = 1'b0;
        bit          prev_stall = 1'b0;
        logic [31:0] pd = 32'h0;
        logic [1:0]  pf = 2'b00;
        n_cap = 0; n_pops = 0; first_cyc = -1; fin_seen = 1'b0; err_seen = 1'b0;
        sop_m = 64'd0; eop_m = 64'd0;
        for (int c = 0; c < budget && !fin_seen; c++) begin
            @(negedge aclk);
            if (pend_pop) begin void'(fifo_q.pop_front()); pend_pop = 1'b0; end
            i_tlp_ready = toggle ? (c % 2 == 0) : 1'b1;
            drive_fifo(bub0 >= 0 && c >= bub0 && c < bub0 + 3);
            #1;
            if (prev_stall && o_tlp_valid) begin
                chk("stall_data", {32'd0, o_tlp_data}, {32'd0, pd});
                chk("stall_flags", {62'd0, o_tlp_sop, o_tlp_eop}, {62'd0, pf});
            end
            if (o_tlp_valid) begin
                prev_stall = !i_tlp_ready;
                pd = o_tlp_data;
                pf = {o_tlp_sop, o_tlp_eop};
            end
            if (o_tlp_valid && i_tlp_ready && n_cap < 64) begin
                if (first_cyc < 0) first_cyc = c;
                cap_dw[n_cap] = o_tlp_data;
                sop_m[n_cap] = o_tlp_sop;
                eop_m[n_cap] = o_tlp_eop;
                n_cap++;
            end
            if (o_payload_rd_en) begin n_pops++; pend_pop = 1'b1; end
            if (o_finished) begin fin_seen = 1'b1; err_seen = o_error; end
        end
        chk("finish_seen", {63'd0, fin_seen}, 64'd1);
        if (!hold) i_valid = 1'b0;
        @(negedge aclk);
        if (pend_pop) void'(fifo_q.pop_front());
        #1;
        chk("fin_one_cycle", {63'd0, o_finished}, 64'd0);
    endtask

    task automatic check_tlp(input string name, input int exp_pops, input bit exp_err);
        chk($sformatf("%s_count", name), 64'(n_cap), 64'(exp_n));
        for (int i = 0; i < exp_n && i < n_cap; i++)
            chk($sformatf("%s_dw%0d", name, i), {32'd0, cap_dw[i]}, {32'd0, exp_dw[i]});
        exp_eop = (exp_n > 0) ? (64'd1 << (exp_n - 1)) : 64'd0;
        chk($sformatf("%s_sop", name), sop_m, (exp_n > 0) ? 64'd1 : 64'd0);
        chk($sformatf("%s_eop", name), eop_m, exp_eop);
        chk($sformatf("%s_pops", name), 64'(n_pops), 64'(exp_pops));
        chk($sformatf("%s_err", name), {63'd0, err_seen}, {63'd0, exp_err});
    endtask

    task automatic set_exp3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        exp_dw[0] = a; exp_dw[1] = b; exp_dw[2] = c; exp_n = 3;
    endtask

    initial begin
        bit any;
        aresetn = 1'b0; i_valid = 1'b0; i_tlp_type = 3'd0; i_addr_64 = 1'b0;
        i_read_write = 1'b0; i_config_type = 1'b0; i_byte_count = 12'd0;
        i_lower_addr = 32'd0; i_upper_addr = 32'd0; i_dest_bdf_id = 16'd0;
        i_config_dw_number = 10'd0; i_tlp_ready = 1'b1;
        drive_fifo(1'b0);
        #1;
        chk("reset_outputs", {o_tlp_data, 26'd0, o_tlp_valid, o_tlp_sop, o_tlp_eop,
                              o_finished, o_error, o_payload_rd_en}, 64'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;

        // MEM read, 32-bit address, tag 0; first DW two cycles after i_valid.
        req(3'd0, 1'b0, 1'b0, 1'b0, 12'd8, 32'h1000_0040, 32'd0, 16'd0, 10'd0);
        collect(40, 1'b0, -1, 1'b0);
        set_exp3(32'h0000_0002, 32'h0100_00FF, 32'h1000_0040);
        check_tlp("mem_rd", 0, 1'b0);
        chk("latency", 64'(first_cyc), 64'd1);

        // MEM write, 64-bit address, 6 bytes, tag 1.
        fifo_q.push_back(32'hAAAA_0001); fifo_q.push_back(32'hBBBB_0002);
        req(3'd0, 1'b1, 1'b1, 1'b0, 12'd6, 32'h2000_0000, 32'h0000_0001, 16'd0, 10'd0);
        collect(40, 1'b0, -1, 1'b0);
        exp_dw[0] = 32'h6000_0002; exp_dw[1] = 32'h0100_013F; exp_dw[2] = 32'h0000_0001;
        exp_dw[3] = 32'h2000_0000; exp_dw[4] = 32'hAAAA_0001; exp_dw[5] = 32'hBBBB_0002;
        exp_n = 6;
        check_tlp("mem_wr64", 2, 1'b0);

        // CFG type1 read, addr_64 ignored, tag 2.
        req(3'd2, 1'b1, 1'b0, 1'b1, 12'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0208, 10'h041);
        collect(40, 1'b0, -1, 1'b0);
        set_exp3(32'h0500_0001, 32'h0100_020F, 32'h0208_0104);
        check_tlp("cfg1_rd", 0, 1'b0);

        // IO write, 2 bytes, tag 3.
        fifo_q.push_back(32'h1234_5678);
        req(3'd1, 1'b1, 1'b1, 1'b0, 12'd2, 32'h0000_1235, 32'h0000_0009, 16'd0, 10'd0);
        collect(40, 1'b0, -1, 1'b0);
        exp_dw[0] = 32'h4200_0001; exp_dw[1] = 32'h0100_0303; exp_dw[2] = 32'h0000_1234;
        exp_dw[3] = 32'h1234_5678; exp_n = 4;
        check_tlp("io_wr", 1, 1'b0);

        // Errors: oversize write (Len 50), unsupported MSG type, Len 33 boundary.
        exp_n = 0;
        req(3'd0, 1'b0, 1'b1, 1'b0, 12'd200, 32'h0, 32'h0, 16'd0, 10'd0);
        collect(40, 1'b0, -1, 1'b0);
        check_tlp("err_len50", 0, 1'b1);
        req(3'd4, 1'b0, 1'b0, 1'b0, 12'd4, 32'h0, 32'h0, 16'd0, 10'd0);
        collect(40, 1'b0, -1, 1'b0);
        check_tlp("err_type4", 0, 1'b1);
        req(3'd0, 1'b0, 1'b1, 1'b0, 12'd129, 32'h0, 32'h0, 16'd0, 10'd0);
        collect(40, 1'b0, -1, 1'b0);
        check_tlp("err_len33", 0, 1'b1);

        // Maximum payload write, Len 32, tag 4 (errors did not consume tags).
        for (int i = 0; i < 32; i++) fifo_q.push_back(32'hC000_0000 + 32'(i));
        req(3'd0, 1'b0, 1'b1, 1'b0, 12'd128, 32'h4000_0000, 32'h0, 16'd0, 10'd0);
        collect(100, 1'b0, -1, 1'b0);
        exp_dw[0] = 32'h4000_0020; exp_dw[1] = 32'h0100_04FF; exp_dw[2] = 32'h4000_0000;
        for (int i = 0; i < 32; i++) exp_dw[3 + i] = 32'hC000_0000 + 32'(i);
        exp_n = 35;
        check_tlp("wr_max", 32, 1'b0);

        // Ready toggling plus 3-cycle FIFO bubble mid-payload, tag 5.
        fifo_q.push_back(32'hCCCC_0003); fifo_q.push_back(32'hDDDD_0004);
        fifo_q.push_back(32'hEEEE_0005);
        req(3'd0, 1'b0, 1'b1, 1'b0, 12'd12, 32'h3000_0007, 32'h0, 16'd0, 10'd0);
        collect(60, 1'b1, 6, 1'b0);
        exp_dw[0] = 32'h4000_0003; exp_dw[1] = 32'h0100_05FF; exp_dw[2] = 32'h3000_0004;
        exp_dw[3] = 32'hCCCC_0003; exp_dw[4] = 32'hDDDD_0004; exp_dw[5] = 32'hEEEE_0005;
        exp_n = 6;
        check_tlp("stall_wr", 3, 1'b0);

        // i_valid held high across o_finished: no reissue, tag 6.
        req(3'd0, 1'b0, 1'b0, 1'b0, 12'd8, 32'h1000_0040, 32'd0, 16'd0, 10'd0);
        collect(40, 1'b0, -1, 1'b1);
        set_exp3(32'h0000_0002, 32'h0100_06FF, 32'h1000_0040);
        check_tlp("hold_rd", 0, 1'b0);
        any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk); #1;
            any = any | o_tlp_valid | o_finished;
        end
        chk("no_reissue", {63'd0, any}, 64'd0);
        i_valid = 1'b0;

        // CFG type0 read after the drop, 3 bytes, max DW number, tag 7.
        req(3'd2, 1'b0, 1'b0, 1'b0, 12'd3, 32'h0, 32'h0, 16'h0100, 10'h3FF);
        collect(40, 1'b0, -1, 1'b0);
        set_exp3(32'h0400_0001, 32'h0100_0707, 32'h0100_0FFC);
        check_tlp("cfg0_rd", 0, 1'b0);

        // Tags 8..31 then wrap to 0.
        for (int t = 8; t <= 32; t++) begin
            req(3'd0, 1'b0, 1'b0, 1'b0, 12'd8, 32'h1000_0040, 32'd0, 16'd0, 10'd0);
            collect(40, 1'b0, -1, 1'b0);
            set_exp3(32'h0000_0002, {16'h0100, 8'(t % 32), 8'hFF}, 32'h1000_0040);
            check_tlp($sformatf("tag%0d", t % 32), 0, 1'b0);
        end

        // Reset mid-TLP: stream drops without eop/finished/pop, tag returns to 0.
        req(3'd0, 1'b0, 1'b0, 1'b0, 12'd8, 32'h1000_0040, 32'd0, 16'd0, 10'd0);
        i_tlp_ready = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        chk("pre_reset_valid", {63'd0, o_tlp_valid}, 64'd1);
        aresetn = 1'b0; i_valid = 1'b0;
        #1;
        chk("mid_reset_outputs", {o_tlp_data, 26'd0, o_tlp_valid, o_tlp_sop, o_tlp_eop,
                                  o_finished, o_error, o_payload_rd_en}, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        req(3'd0, 1'b0, 1'b0, 1'b0, 12'd8, 32'h1000_0040, 32'd0, 16'd0, 10'd0);
        collect(40, 1'b0, -1, 1'b0);
        set_exp3(32'h0000_0002, 32'h0100_00FF, 32'h1000_0040);
        check_tlp("after_reset", 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_tlp_builder.md
Name: tx_tlp_builder

Overview:
- Downstream neighbour of the TX AXI-Lite request register block. Consumes the decoded request fields, the valid flag and the payload FIFO read port (first-word fall-through).
- Serialises one PCIe request TLP as a DW stream (header, then payload) to the TX data-link stage.
- Pulses i_finished back upstream, which clears the request's valid flag.

Parameters:
- REQUESTER_ID, 16'h0100, requester BDF placed in header DW1.
- MAX_PAYLOAD_DW, 32, max write payload in DW; equals payload FIFO depth.
- TAG_WIDTH, 5, width of the tag counter; the tag is zero-extended to 8 bits.

Ports:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- i_tlp_type  in  3  0=MEM, 1=IO, 2=CFG, 4=MSG (unsupported), others unsupported
- i_addr_64  in  1  1=4DW header (MEM only)
- i_read_write  in  1  1=write, 0=read
- i_config_type  in  1  0=CFG type0, 1=CFG type1
- i_byte_count  in  12  request size in bytes
- i_lower_addr  in  32  address [31:0]
- i_upper_addr  in  32  address [63:32]
- i_dest_bdf_id  in  16  CFG completer BDF
- i_config_dw_number  in  10  CFG register DW number
- i_valid  in  1  request pending (level)
- i_payload_data  in  32  FIFO head word (fall-through)
- i_payload_empty  in  1  FIFO empty
- o_payload_rd_en  out  1  FIFO pop
- o_finished  out  1  one-cycle done pulse
- o_error  out  1  one-cycle error pulse, coincident with o_finished
- o_tlp_data  out  32  stream DW
- o_tlp_sop  out  1  first DW of TLP
- o_tlp_eop  out  1  last DW of TLP
- o_tlp_valid  out  1  stream valid
- i_tlp_ready  in  1  stream ready

Behaviour:
- Reset: FSM=IDLE, tag=0, all outputs 0, header regs 0. Reset mid-TLP aborts the TLP with no eop, no finished pulse and no FIFO pop.
- States: IDLE, CHECK, HDR, DATA, DONE, WAIT_CLR.
- IDLE->CHECK when i_valid=1. All request fields are latched on this edge.
- CHECK (1 cycle): Len=(byte_count+3)>>2, with minimum 1. IO and CFG force Len=1 and a 3DW header; i_addr_64 is ignored for them.
- CHECK errors: unsupported type, or (write && Len>MAX_PAYLOAD_DW). On error go to DONE with o_error=1 and emit no TLP. Otherwise go to HDR with DW index 0.
- DW0: Fmt[31:29]={0, write, hdr4}; Type[28:24]=MEM 00000, IO 00010, CFG0 00100, CFG1 00101; TD[15] per the optional feature; Length[9:0]=Len (1024 encodes as 0). All other bits 0.
- DW1: {REQUESTER_ID, tag, lastBE, firstBE}.
  - Len==1: firstBE from byte_count[1:0] (1->0001, 2->0011, 3->0111, 0->1111); lastBE=0000.
  - Len>1: firstBE=1111; lastBE from the same remainder encoding.
- DW2 for MEM/IO 3DW: {lower_addr[31:2], 2'b00}.
- DW2 for CFG: {bdf, 4'h0, dw_number[9:6], dw_number[5:0], 2'b00}.
- MEM 4DW: DW2=upper_addr, DW3={lower_addr[31:2], 2'b00}.
- HDR: o_tlp_valid=1. The DW index advances only on valid&&ready; data, sop and eop are held stable while stalled. sop on DW0.
  - Read: eop on the last header DW, then DONE.
  - Write: go to DATA after the last header DW.
- DATA: o_tlp_valid=!i_payload_empty; o_tlp_data=i_payload_data; o_payload_rd_en=valid&&ready. A down-counter loaded with Len decrements per transfer. eop when count==1, then DONE after that transfer.
- DONE: o_finished=1 for exactly one cycle, then WAIT_CLR. The tag increments (mod 2^TAG_WIDTH) only for TLPs actually emitted.
- WAIT_CLR: stay until i_valid=0, then IDLE. This prevents a stale level from re-issuing the request.
- Latency: first header DW is valid 2 cycles after i_valid rises (IDLE, CHECK).
- FIFO empty mid-payload: insert bubbles; the TLP is never truncated.

Optional Feature:
- Macro: TX_TLP_DIGEST_EN.
- With the macro defined: TD=1 in DW0. One extra DW is appended after the last header or payload DW, equal to the XOR of all DWs emitted in that TLP. eop moves to this digest DW.
- Without the macro: TD=0, no digest logic, and eop is as described in Behaviour.

Test Plan:
- MEM read, 32-bit address, byte_count=8, addr=0x1000_0040, ready=1 -> 3 DWs: 0x0000_0002, 0x0100_00FF, 0x1000_0040. sop on DW0, eop on DW2, o_finished one cycle later.
- MEM write, 64-bit address, byte_count=6, upper=0x1, lower=0x2000_0000, FIFO holds A,B -> DW0=0x6000_0002, DW1 BE nibbles 0011/1111, then 0x1, 0x2000_0000, A, B. Two FIFO pops, eop on B.
- CFG type1 read, bdf=0x0208, dw_number=0x041 -> DW0=0x0500_0001, DW2=0x0208_0104.
- Write with byte_count=200 (Len 50 > 32) -> no stream activity, o_error and o_finished pulse together, tag unchanged.
- i_tlp_ready toggling 1/0 and FIFO empty for 3 cycles mid-payload -> DWs unchanged while stalled, no duplicate or skipped DW, exact Len pops.
- Back-to-back: i_valid held high across o_finished -> no reissue until i_valid drops. The next request carries tag+1; tag 31 wraps to 0.
